// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM port among NUM_CH load/store requestors.
// Define RAM_ARBITER_MISALIGN_ERR_EN to reject misaligned half/word accesses through resp_err.
module ram_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int LATENCY = 2,
    parameter int WORD_W  = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_CH-1:0]        req_ren,
    input  logic [NUM_CH-1:0]        req_wen,
    input  logic [NUM_CH*WORD_W-1:0] req_addr,
    input  logic [NUM_CH*WORD_W-1:0] req_wdata,
    input  logic [NUM_CH*3-1:0]      req_funct3,
    output logic [NUM_CH-1:0]        resp_ready,
    output logic [WORD_W-1:0]        resp_rdata,
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
    output logic                     resp_err,
`endif
    output logic                     mem_ren,
    output logic                     mem_wen,
    output logic [WORD_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    output logic [3:0]               mem_strobe,
    input  logic [WORD_W-1:0]        mem_rdata
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [CH_W-1:0]   ptr_q, gnt_q, gnt_idx;
    logic              gnt_valid, mask_q, write_q, misalign, last_wait;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
    logic [2:0]        funct3_q, sel_f3;
    logic [WORD_W-1:0] sel_addr, sel_wd, sel_wdata, lane, load_data;
    logic [3:0]        strobe;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
    logic              err_q;
`endif

    // The channel just served is skipped for one IDLE cycle so a requestor still
    // holding its request while it sees resp_ready is not granted twice.
    always_comb begin : arbitrate
        int cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (int'(ptr_q) + k) % NUM_CH;
            if (!gnt_valid && (req_ren[cand] || req_wen[cand]) &&
                !(mask_q && gnt_q == CH_W'(cand))) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
        end
    end

    always_comb begin
        sel_addr = req_addr[int'(gnt_idx)*WORD_W +: WORD_W];
        sel_wd   = req_wdata[int'(gnt_idx)*WORD_W +: WORD_W];
        sel_f3   = req_funct3[int'(gnt_idx)*3 +: 3];
        case (sel_f3[1:0])
            2'd0:    sel_wdata = {(WORD_W/8){sel_wd[7:0]}};
            2'd1:    sel_wdata = {(WORD_W/16){sel_wd[15:0]}};
            default: sel_wdata = sel_wd;
        endcase
    end

`ifdef RAM_ARBITER_MISALIGN_ERR_EN
    assign misalign = (sel_f3[1:0] == 2'd1 && sel_addr[0]) ||
                      (sel_f3[1] && sel_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Low address bits finer than the access size are ignored, so halves and words are forced aligned.
    always_comb begin
        lane      = mem_rdata;
        load_data = mem_rdata;
        strobe    = 4'b1111;
        case (funct3_q[1:0])
            2'd0: begin
                lane      = mem_rdata >> {addr_q[1:0], 3'b000};
                load_data = {{(WORD_W-8){!funct3_q[2] && lane[7]}}, lane[7:0]};
                strobe    = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                lane      = mem_rdata >> {addr_q[1], 4'b0000};
                load_data = {{(WORD_W-16){!funct3_q[2] && lane[15]}}, lane[15:0]};
                strobe    = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign last_wait = (cnt_q == 4'(LATENCY - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_valid) state_d = misalign ? S_DONE : S_WAIT;
            S_WAIT:  if (last_wait) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            mask_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (gnt_valid) begin
                        gnt_q    <= gnt_idx;
                        write_q  <= req_wen[gnt_idx];
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        funct3_q <= sel_f3;
                        rdata_q  <= '0;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
                        err_q    <= misalign;
`endif
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (last_wait) rdata_q <= write_q ? '0 : load_data;
                end
                S_DONE: begin
                    cnt_q  <= '0;
                    ptr_q  <= (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + CH_W'(1);
                    mask_q <= 1'b1;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    always_comb begin
        resp_ready = '0;
        if (state_q == S_DONE) resp_ready[gnt_q] = 1'b1;
    end

    assign resp_rdata = (state_q == S_DONE) ? rdata_q : '0;
    assign mem_ren    = (state_q == S_WAIT) && !write_q;
    assign mem_wen    = (state_q == S_WAIT) && write_q;
    assign mem_addr   = (state_q == S_WAIT) ? {addr_q[WORD_W-1:2], 2'b00} : '0;
    assign mem_wdata  = (state_q == S_WAIT && write_q) ? wdata_q : '0;
    assign mem_strobe = (state_q == S_WAIT) ? strobe : 4'b0000;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
    assign resp_err   = (state_q == S_DONE) && err_q;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a timeline model of grants and responses checked every
// cycle, plus directed accesses with hand-computed results.
module tb_ram_arbiter;
    localparam int NUM_CH  = 2;
    localparam int LATENCY = 2;
    localparam int WORD_W  = 32;

    logic                     CLK = 1'b0;
    logic                     nRST;
    logic [NUM_CH-1:0]        req_ren, req_wen;
    logic [NUM_CH*WORD_W-1:0] req_addr, req_wdata;
    logic [NUM_CH*3-1:0]      req_funct3;
    logic [NUM_CH-1:0]        resp_ready;
    logic [WORD_W-1:0]        resp_rdata;
    logic                     mem_ren, mem_wen;
    logic [WORD_W-1:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]               mem_strobe;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
    logic                     resp_err;
`endif

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.NUM_CH(NUM_CH), .LATENCY(LATENCY), .WORD_W(WORD_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_ren    (req_ren),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
        .resp_err   (resp_err),
`endif
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strobe (mem_strobe),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v;
        v = word;
        if (f3[1:0] == 2'd0) begin
            v = (word >> (8 * (addr % 4))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (f3[1:0] == 2'd1) begin
            v = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strobe(input logic [31:0] addr, input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 4'(1 << (addr % 4));
        if (f3[1:0] == 2'd1) return 4'(3 << (2 * ((addr / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // Model state: the last granted access and the edge numbers at which it was granted and answered.
    int          m_edge, m_grant_edge, m_resp_edge, m_ptr, m_ch;
    bit          m_active, m_write, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_f3;

    always @(posedge CLK) begin : scoreboard
        int  masked;
        bit  idle, mem_phase, resp_phase;
        if (!nRST) begin
            m_active = 1'b0;
            m_ptr    = 0;
            m_edge   = 0;
        end else begin
            m_edge++;
            if (m_active && m_edge == m_resp_edge + 1) m_ptr = (m_ch + 1) % NUM_CH;
            idle   = !m_active || (m_edge >= m_resp_edge + 2);
            masked = (m_active && m_edge == m_resp_edge + 2) ? m_ch : -1;
            if (m_active && !m_err && m_edge == m_grant_edge + LATENCY)
                m_rdata = m_write ? 32'h0 : model_load(mem_rdata, m_addr, m_f3);
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CH;
                if (idle && (req_ren[c] || req_wen[c]) && c != masked) begin
                    idle         = 1'b0;
                    m_active     = 1'b1;
                    m_ch         = c;
                    m_grant_edge = m_edge;
                    m_write      = req_wen[c];
                    m_addr       = req_addr[c*WORD_W +: WORD_W];
                    m_wdata      = req_wdata[c*WORD_W +: WORD_W];
                    m_f3         = req_funct3[c*3 +: 3];
                    m_rdata      = 32'h0;
                    m_err        = 1'b0;
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
                    m_err = (m_f3[1:0] == 2'd1 && m_addr % 2 != 0) || (m_f3[1] && m_addr % 4 != 0);
`endif
                    m_resp_edge  = m_err ? m_edge : m_edge + LATENCY;
                end
            end
        end
        #1;
        mem_phase  = m_active && !m_err && m_edge >= m_grant_edge && m_edge < m_grant_edge + LATENCY;
        resp_phase = m_active && m_edge == m_resp_edge;
        check_output("cyc_mem_ren", 32'(mem_ren), 32'(mem_phase && !m_write));
        check_output("cyc_mem_wen", 32'(mem_wen), 32'(mem_phase && m_write));
        check_output("cyc_mem_addr", mem_addr, mem_phase ? (m_addr & 32'hFFFFFFFC) : 32'h0);
        check_output("cyc_mem_wdata", mem_wdata, (mem_phase && m_write) ? model_wdata(m_wdata, m_f3) : 32'h0);
        check_output("cyc_mem_strobe", 32'(mem_strobe), mem_phase ? 32'(model_strobe(m_addr, m_f3)) : 32'h0);
        check_output("cyc_resp_ready", 32'(resp_ready), resp_phase ? (32'h1 << m_ch) : 32'h0);
        check_output("cyc_resp_rdata", resp_rdata, resp_phase ? m_rdata : 32'h0);
`ifdef RAM_ARBITER_MISALIGN_ERR_EN
        check_output("cyc_resp_err", 32'(resp_err), 32'(resp_phase && m_err));
`endif
    end

    task automatic apply_stimulus(input int ch, input logic ren, input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3);
        req_ren[ch]                    = ren;
        req_wen[ch]                    = wen;
        req_addr[ch*WORD_W +: WORD_W]  = addr;
        req_wdata[ch*WORD_W +: WORD_W] = wdata;
        req_funct3[ch*3 +: 3]          = f3;
    endtask

    task automatic release_req(input int ch);
        req_ren[ch] = 1'b0;
        req_wen[ch] = 1'b0;
    endtask

    task automatic wait_resp(output int ch);
        ch = -1;
        for (int i = 0; i < 40 && ch < 0; i++) begin
            @(negedge CLK);
            for (int c = 0; c < NUM_CH; c++) if (resp_ready[c]) ch = c;
        end
        checks++;
        if (ch < 0) begin
            failures++;
            $display("[TB] FAIL resp_timeout: got no resp_ready, expected a pulse within 40 cycles at %0t", $time);
        end
    endtask

    // Requestor keeps its request through the cycle after resp_ready, then drops it.
    task automatic do_access(input string name, input int ch, input logic ren, input logic wen,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                             input logic [31:0] rd, input logic [31:0] exp_rdata);
        int got;
        @(negedge CLK);
        mem_rdata = rd;
        apply_stimulus(ch, ren, wen, addr, wdata, f3);
        wait_resp(got);
        check_output({name, "_ch"}, 32'(got), 32'(ch));
        check_output({name, "_rdata"}, resp_rdata, exp_rdata);
        repeat (2) @(negedge CLK);
        release_req(ch);
    endtask

    initial begin : stimulus
        int got;
        nRST       = 1'b0;
        req_ren    = '0;
        req_wen    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        mem_rdata  = '0;
        repeat (3) @(negedge CLK);
        check_output("reset_resp_ready", 32'(resp_ready), 32'h0);
        check_output("reset_mem_ren", 32'(mem_ren), 32'h0);
        check_output("reset_mem_strobe", 32'(mem_strobe), 32'h0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("[TB] ch1 LW at 0x104");
        mem_rdata = 32'hDEADBEEF;
        apply_stimulus(1, 1'b1, 1'b0, 32'h104, 32'h0, 3'd2);
        for (int i = 0; i < LATENCY; i++) begin
            @(negedge CLK);
            check_output("lw_mem_ren", 32'(mem_ren), 32'h1);
            check_output("lw_mem_addr", mem_addr, 32'h104);
            check_output("lw_no_resp", 32'(resp_ready), 32'h0);
        end
        @(negedge CLK);
        check_output("lw_resp_ready", 32'(resp_ready), 32'h2);
        check_output("lw_resp_rdata", resp_rdata, 32'hDEADBEEF);
        check_output("lw_mem_ren_off", 32'(mem_ren), 32'h0);
        repeat (2) @(negedge CLK);
        release_req(1);
        repeat (3) @(negedge CLK);

        $display("[TB] round-robin between ch0 and ch1");
        mem_rdata = 32'h11111111;
        apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        apply_stimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        wait_resp(got);
        check_output("rr_first", 32'(got), 32'h0);
        wait_resp(got);
        check_output("rr_second", 32'(got), 32'h1);
        @(negedge CLK);
        release_req(1);
        wait_resp(got);
        check_output("rr_third", 32'(got), 32'h0);
        @(negedge CLK);
        release_req(0);
        repeat (3) @(negedge CLK);

        $display("[TB] SB with ren and wen both high");
        mem_rdata = 32'h12345678;
        apply_stimulus(0, 1'b1, 1'b1, 32'h203, 32'hA5, 3'd0);
        @(negedge CLK);
        check_output("sb_mem_wen", 32'(mem_wen), 32'h1);
        check_output("sb_mem_ren", 32'(mem_ren), 32'h0);
        check_output("sb_strobe", 32'(mem_strobe), 32'h8);
        check_output("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        wait_resp(got);
        check_output("sb_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge CLK);
        release_req(0);

        $display("[TB] load extension and store lanes");
        do_access("lb",  0, 1'b1, 1'b0, 32'h2, 32'h0, 3'd0, 32'h00800000, 32'hFFFFFF80);
        do_access("lbu", 1, 1'b1, 1'b0, 32'h2, 32'h0, 3'd4, 32'h00800000, 32'h00000080);
        do_access("lhu", 0, 1'b1, 1'b0, 32'h2, 32'h0, 3'd5, 32'h80010000, 32'h00008001);
        do_access("lh",  1, 1'b1, 1'b0, 32'h2, 32'h0, 3'd1, 32'h80010000, 32'hFFFF8001);
        do_access("sh",  0, 1'b0, 1'b1, 32'h6, 32'h1234BEEF, 3'd1, 32'h0, 32'h0);
        do_access("sw",  1, 1'b0, 1'b1, 32'h8, 32'h01020304, 3'd2, 32'h0, 32'h0);
        do_access("lb3", 0, 1'b1, 1'b0, 32'h7, 32'h0, 3'd0, 32'h7F000000, 32'h0000007F);

`ifdef RAM_ARBITER_MISALIGN_ERR_EN
        $display("[TB] misaligned LW rejected");
        @(negedge CLK);
        mem_rdata = 32'hCAFEF00D;
        apply_stimulus(1, 1'b1, 1'b0, 32'h102, 32'h0, 3'd2);
        @(negedge CLK);
        check_output("mis_resp_ready", 32'(resp_ready), 32'h2);
        check_output("mis_resp_err", 32'(resp_err), 32'h1);
        check_output("mis_mem_ren", 32'(mem_ren), 32'h0);
        check_output("mis_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge CLK);
        release_req(1);
`else
        $display("[TB] misaligned accesses forced aligned");
        do_access("lw_align", 1, 1'b1, 1'b0, 32'h103, 32'h0, 3'd2, 32'hCAFEF00D, 32'hCAFEF00D);
        do_access("lh_align", 0, 1'b1, 1'b0, 32'h3, 32'h0, 3'd1, 32'h80010000, 32'hFFFF8001);
`endif
        repeat (3) @(negedge CLK);

        $display("[TB] reset during second wait cycle");
        mem_rdata = 32'h55;
        apply_stimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'd2);
        @(negedge CLK);
        check_output("abort_wait1_ren", 32'(mem_ren), 32'h1);
        @(negedge CLK);
        check_output("abort_wait2_ren", 32'(mem_ren), 32'h1);
        nRST = 1'b0;
        #1;
        check_output("abort_ren_drop", 32'(mem_ren), 32'h0);
        check_output("abort_addr_drop", mem_addr, 32'h0);
        @(negedge CLK);
        check_output("abort_no_resp", 32'(resp_ready), 32'h0);
        nRST = 1'b1;
        mem_rdata = 32'h77;
        apply_stimulus(0, 1'b1, 1'b0, 32'h80, 32'h0, 3'd2);
        wait_resp(got);
        check_output("abort_next_grant", 32'(got), 32'h0);
        check_output("abort_next_rdata", resp_rdata, 32'h77);
        repeat (2) @(negedge CLK);
        release_req(0);
        wait_resp(got);
        check_output("abort_reissue", 32'(got), 32'h1);
        repeat (2) @(negedge CLK);
        release_req(1);

        repeat (4) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, expected it before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
